// File: rtl/bus_pkg.sv
// Shared bus-arbiter definitions: FSM encoding, bus widths and the data
// returned to a master whose transaction was forcibly terminated.
package bus_pkg;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } bus_state_t;

    localparam int BUS_ADDR_W = 32;
    localparam int BUS_DATA_W = 32;

    localparam logic [BUS_DATA_W-1:0] BUS_TIMEOUT_RDATA = 32'hDEADBEEF;

endpackage

// File: rtl/bus_arbiter_rr_pick.sv
// Round-robin pick: first set request scanning upward from last_idx+1 with wrap.
// Purely combinational, zero latency; no flow control of its own.
module bus_arbiter_rr_pick #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic [NUM_REQ-1:0] req_vec,
    input  logic [IDX_W-1:0]   last_idx,
    output logic               pick_vld,
    output logic [IDX_W-1:0]   pick_idx
);

    int k;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        pick_vld = 1'b0;
        pick_idx = '0;
        k        = 0;
        for (int off = NUM_REQ; off >= 1; off--) begin
            k = (int'(last_idx) + off) % NUM_REQ;
            if (req_vec[k]) begin
                pick_vld = 1'b1;
                pick_idx = IDX_W'(k);
            end
        end
    end

endmodule

// File: rtl/bus_arbiter.sv
// Round-robin bus arbiter: one-cycle arbitration in IDLE, then the owner's request is forwarded
// combinationally until ready; others wait. Optional BUS_ARBITER_TIMEOUT_EN forces termination.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                              i_clock,
    input  logic                              i_reset_n,
    input  logic [NUM_MASTERS-1:0]            i_request,
    input  logic [NUM_MASTERS-1:0]            i_rw,
    input  logic [BUS_ADDR_W*NUM_MASTERS-1:0] i_address,
    input  logic [BUS_DATA_W*NUM_MASTERS-1:0] i_wdata,
    output logic [BUS_DATA_W-1:0]             o_rdata,
    output logic [NUM_MASTERS-1:0]            o_ready,
    output logic                              o_bus_request,
    output logic                              o_bus_rw,
    output logic [BUS_ADDR_W-1:0]             o_bus_address,
    output logic [BUS_DATA_W-1:0]             o_bus_wdata,
    input  logic [BUS_DATA_W-1:0]             i_bus_rdata,
    input  logic                              i_bus_ready,
    output logic [NUM_MASTERS-1:0]            o_grant,
    output logic                              o_timeout
);

    localparam int IDX_W = $clog2(NUM_MASTERS);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4) begin : g_bad_num_masters
        $error("bus_arbiter: NUM_MASTERS must be 2..4");
    end
    if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65536) begin : g_bad_timeout
        $error("bus_arbiter: TIMEOUT_CYCLES must fit the 16-bit counter");
    end

    bus_state_t       state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic             pick_vld;
    logic [IDX_W-1:0] pick_idx;
    logic             own_req;
    logic             done;
    logic             expire;

    bus_arbiter_rr_pick #(
        .NUM_REQ (NUM_MASTERS),
        .IDX_W   (IDX_W)
    ) u_rr_pick (
        .req_vec  (i_request),
        .last_idx (last_grant_q),
        .pick_vld (pick_vld),
        .pick_idx (pick_idx)
    );

    assign own_req = i_request[grant_q];
    assign done    = (state_q == ST_BUSY) && own_req && i_bus_ready;

`ifdef BUS_ARBITER_TIMEOUT_EN
    logic [15:0] to_cnt_q, to_cnt_d;
    logic        to_flag_q, to_flag_d;

    // A real ready on the expiry cycle takes precedence over forced termination.
    always_comb begin
        expire    = (state_q == ST_BUSY) && own_req && !i_bus_ready &&
                    (to_cnt_q == 16'(TIMEOUT_CYCLES - 1));
        to_cnt_d  = (state_q == ST_BUSY) ? to_cnt_q + 16'd1 : 16'd0;
        to_flag_d = to_flag_q | expire;
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            to_cnt_q  <= 16'd0;
            to_flag_q <= 1'b0;
        end else begin
            to_cnt_q  <= to_cnt_d;
            to_flag_q <= to_flag_d;
        end
    end

    assign o_timeout = to_flag_q;
`else
    assign expire    = 1'b0;
    assign o_timeout = 1'b0;
`endif

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(NUM_MASTERS - 1);
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
        end
    end

    // A dropped request ends ownership too, and still rotates priority.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d = ST_BUSY;
                    grant_d = pick_idx;
                end
            end
            ST_BUSY: begin
                if (done || expire || !own_req) begin
                    state_d      = ST_IDLE;
                    last_grant_d = grant_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        o_grant       = '0;
        o_ready       = '0;
        o_rdata       = '0;
        o_bus_request = 1'b0;
        o_bus_rw      = 1'b0;
        o_bus_address = '0;
        o_bus_wdata   = '0;
        if (state_q == ST_BUSY) begin
            o_grant[grant_q] = 1'b1;
            o_bus_request    = own_req && !expire;
            o_bus_rw         = i_rw[grant_q];
            o_bus_address    = i_address[BUS_ADDR_W*int'(grant_q) +: BUS_ADDR_W];
            o_bus_wdata      = i_wdata[BUS_DATA_W*int'(grant_q) +: BUS_DATA_W];
            o_rdata          = expire ? BUS_TIMEOUT_RDATA : i_bus_rdata;
            if (done || expire) begin
                o_ready[grant_q] = 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: scoreboard of expected completions, immediate-assertion checks.
module tb_bus_arbiter;
    import bus_pkg::*;

    localparam int N = 2;
`ifdef BUS_ARBITER_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 1024;
`endif

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic [N-1:0]    i_request = '0;
    logic [N-1:0]    i_rw = '0;
    logic [32*N-1:0] i_address = '0;
    logic [32*N-1:0] i_wdata = '0;
    logic [31:0]     o_rdata;
    logic [N-1:0]    o_ready;
    logic            o_bus_request;
    logic            o_bus_rw;
    logic [31:0]     o_bus_address;
    logic [31:0]     o_bus_wdata;
    logic [31:0]     i_bus_rdata = '0;
    logic            i_bus_ready = 1'b0;
    logic [N-1:0]    o_grant;
    logic            o_timeout;

    always #5 clk = ~clk;

    bus_arbiter #(
        .NUM_MASTERS    (N),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .i_clock       (clk),
        .i_reset_n     (rst_n),
        .i_request     (i_request),
        .i_rw          (i_rw),
        .i_address     (i_address),
        .i_wdata       (i_wdata),
        .o_rdata       (o_rdata),
        .o_ready       (o_ready),
        .o_bus_request (o_bus_request),
        .o_bus_rw      (o_bus_rw),
        .o_bus_address (o_bus_address),
        .o_bus_wdata   (o_bus_wdata),
        .i_bus_rdata   (i_bus_rdata),
        .i_bus_ready   (i_bus_ready),
        .o_grant       (o_grant),
        .o_timeout     (o_timeout)
    );

    typedef struct {
        int          m;
        logic [31:0] rdata;
    } exp_t;

    exp_t sb[$];
    int   n_assert = 0;
    int   n_fail = 0;
    int   ready_cnt0 = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample at the falling edge; every ready pulse must match the head of the scoreboard.
    task automatic sample();
        exp_t e;
        @(negedge clk);
        check("grant_onehot", 32'($countones(o_grant) <= 1), 32'd1);
        if (o_ready != '0) begin
            if (o_ready[0]) ready_cnt0++;
            if (sb.size() == 0) begin
                check("unexpected_ready", 32'(o_ready), 32'd0);
            end else begin
                e = sb.pop_front();
                check("ready_owner", 32'(o_ready), 32'(1 << e.m));
                check("ready_rdata", o_rdata, e.rdata);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int m, input logic [31:0] rd);
        exp_t e;
        e.m     = m;
        e.rdata = rd;
        sb.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_grant"}, 32'(o_grant), 32'd0);
        check({tag, "_ready"}, 32'(o_ready), 32'd0);
        check({tag, "_bus_req"}, 32'(o_bus_request), 32'd0);
        check({tag, "_bus_rw"}, 32'(o_bus_rw), 32'd0);
        check({tag, "_bus_addr"}, o_bus_address, 32'd0);
        check({tag, "_bus_wdata"}, o_bus_wdata, 32'd0);
        check({tag, "_rdata"}, o_rdata, 32'd0);
    endtask

    initial begin
        int last;
        int m;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        check("reset_timeout", 32'(o_timeout), 32'd0);
        rst_n = 1'b1;

        // Single write from master 0, ready two cycles after the request
        i_request = 2'b01;
        i_rw      = 2'b01;
        i_address[31:0] = 32'h0001_0004;
        i_wdata[31:0]   = 32'h1234_5678;
        sample();
        check("t1_arb_grant", 32'(o_grant), 32'd0);
        check("t1_arb_bus_req", 32'(o_bus_request), 32'd0);
        adv();
        sample();
        check("t1_grant", 32'(o_grant), 32'b01);
        check("t1_bus_req", 32'(o_bus_request), 32'd1);
        check("t1_bus_rw", 32'(o_bus_rw), 32'd1);
        check("t1_bus_addr", o_bus_address, 32'h0001_0004);
        check("t1_bus_wdata", o_bus_wdata, 32'h1234_5678);
        check("t1_no_early_ready", 32'(o_ready), 32'd0);
        adv();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h0;
        push(0, 32'h0);
        sample();
        adv();
        i_request   = '0;
        i_bus_ready = 1'b0;
        sample();
        check("t1_idle_grant", 32'(o_grant), 32'd0);
        check("t1_idle_bus_req", 32'(o_bus_request), 32'd0);
        check("t1_ready_once", 32'(ready_cnt0), 32'd1);
        adv();

        // Both masters request continuously with an always-ready slave
        i_request = 2'b11;
        i_rw      = 2'b00;
        i_address[31:0]  = 32'hA000_0000;
        i_address[63:32] = 32'hB000_0000;
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1111_0000;
        last = 0;
        for (int c = 0; c < 8; c++) begin
            if (c % 2 == 0) begin
                sample();
                check("t2_idle_grant", 32'(o_grant), 32'd0);
            end else begin
                m = (last + 1) % N;
                push(m, 32'h1111_0000);
                sample();
                check("t2_grant", 32'(o_grant), 32'(1 << m));
                check("t2_bus_addr", o_bus_address, (m == 0) ? 32'hA000_0000 : 32'hB000_0000);
                last = m;
            end
            adv();
        end
        i_request   = '0;
        i_bus_ready = 1'b0;

        // Master 1 read; master 0 requests mid-transaction and waits
        i_request = 2'b10;
        i_address[63:32] = 32'h5000_0010;
        sample();
        adv();
        i_request = 2'b11;
        sample();
        check("t3_grant", 32'(o_grant), 32'b10);
        check("t3_bus_addr", o_bus_address, 32'h5000_0010);
        check("t3_bus_rw", 32'(o_bus_rw), 32'd0);
        check("t3_no_ready", 32'(o_ready), 32'd0);
        adv();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'hA5A5_A5A5;
        push(1, 32'hA5A5_A5A5);
        sample();
        adv();
        i_request   = 2'b01;
        i_bus_ready = 1'b0;
        sample();
        check("t3_idle", 32'(o_grant), 32'd0);
        adv();
        sample();
        check("t3_m0_next", 32'(o_grant), 32'b01);
        adv();

        // Reset during BUSY with ready pending aborts asynchronously
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h7777_7777;
        rst_n = 1'b0;
        #1;
        check_all_zero("t4_async");
        sample();
        check("t4_no_ready", 32'(o_ready), 32'd0);
        adv();
        rst_n       = 1'b1;
        i_bus_ready = 1'b0;
        i_request   = 2'b11;
        sample();
        adv();
        sample();
        check("t4_prio_after_reset", 32'(o_grant), 32'b01);
        adv();

        // Owner drops its request before ready; priority still rotates
        i_request = 2'b10;
        sample();
        check("t6_drop_no_ready", 32'(o_ready), 32'd0);
        check("t6_drop_bus_req", 32'(o_bus_request), 32'd0);
        adv();
        i_request = 2'b11;
        sample();
        check("t6_idle", 32'(o_grant), 32'd0);
        adv();
        sample();
        check("t6_other_granted", 32'(o_grant), 32'b10);
        adv();
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h0BAD_F00D;
        push(1, 32'h0BAD_F00D);
        sample();
        adv();
        i_request   = '0;
        i_bus_ready = 1'b0;
        sample();
        check("t6_end_idle", 32'(o_grant), 32'd0);
        adv();

`ifdef BUS_ARBITER_TIMEOUT_EN
        // Slave never ready: forced completion on BUSY cycle TO
        i_request = 2'b01;
        sample();
        adv();
        for (int b = 1; b <= TO; b++) begin
            if (b == TO) push(0, 32'hDEAD_BEEF);
            sample();
            if (b < TO) begin
                check("t5_wait_no_ready", 32'(o_ready), 32'd0);
                check("t5_wait_bus_req", 32'(o_bus_request), 32'd1);
            end else begin
                check("t5_expire_bus_req", 32'(o_bus_request), 32'd0);
            end
            adv();
        end
        i_request   = 2'b10;
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h1212_1212;
        sample();
        check("t5_flag_set", 32'(o_timeout), 32'd1);
        check("t5_idle", 32'(o_grant), 32'd0);
        adv();
        push(1, 32'h1212_1212);
        sample();
        check("t5_next_grant", 32'(o_grant), 32'b10);
        adv();
        i_request   = '0;
        i_bus_ready = 1'b0;
        sample();
        check("t5_flag_sticky", 32'(o_timeout), 32'd1);
        adv();
`else
        // Without the timeout feature a stalled slave holds the bus indefinitely
        i_request = 2'b01;
        sample();
        adv();
        for (int b = 0; b < 20; b++) begin
            sample();
            check("t5_wait_no_ready", 32'(o_ready), 32'd0);
            check("t5_no_timeout", 32'(o_timeout), 32'd0);
            adv();
        end
        i_bus_ready = 1'b1;
        i_bus_rdata = 32'h3333_4444;
        push(0, 32'h3333_4444);
        sample();
        adv();
        i_request   = '0;
        i_bus_ready = 1'b0;
        sample();
        check("t5_end_idle", 32'(o_grant), 32'd0);
        adv();
`endif

        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
